// File: rtl/bin_to_dec_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_dec_seq_if
//  Description : Request/result bundle for the sequential binary-to-BCD
//                converter. The requester drives start/binary and observes
//                busy/done and the registered result (digits, overflow,
//                negative).
//  Ports       : start    - conversion request (requester -> converter)
//                binary   - value to convert, WIDTH bits
//                busy     - conversion in progress
//                done     - one-cycle result-update pulse
//                digits   - BCD result, 4*DIGITS bits, units digit in [3:0]
//                overflow - result did not fit in DIGITS digits
//                negative - sign of the last converted value
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_dec_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   digits;
    logic                  overflow;
    logic                  negative;

    // Requester side (bus master / testbench)
    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  digits,
        input  overflow,
        input  negative
    );

    // Converter side
    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output digits,
        output overflow,
        output negative
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_dec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_dec_seq
//  Description : Sequential binary-to-BCD converter using iterative
//                double-dabble (shift-add-3), one input bit per clock.
//                Combinational depth is a single per-digit adjust stage.
//                A conversion accepted on edge E presents its result with a
//                one-cycle done pulse after edge E+WIDTH; busy is high for
//                exactly WIDTH cycles. A new start may be accepted on the
//                same cycle that done is high.
//
//  Parameters  : WIDTH  - input binary width (>= 4)
//                DIGITS - number of BCD digits produced (>= 1)
//
//  Ports       : clock    - system clock, rising edge
//                reset    - synchronous, active-high reset
//                bus      - bin_to_dec_seq_if.slave:
//                           start/binary in; busy/done/digits/overflow/
//                           negative out
//
//  Options     : SIGNED_EN - when defined, binary is two's complement; the
//                            magnitude is converted and negative reports the
//                            sign. When undefined, negative is tied to 0 and
//                            no negation logic exists.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_dec_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  wire logic          clock,
    input  wire logic          reset,
    bin_to_dec_seq_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          C_CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          C_AW    = 4 * DIGITS;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [WIDTH-1:0]    sr_q,       sr_d;       // remaining binary bits
    logic [C_AW-1:0]     acc_q,      acc_d;      // BCD accumulator
    logic                ovf_q,      ovf_d;      // sticky overflow
    logic [C_CW-1:0]     count_q,    count_d;    // shifts remaining - 1
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [C_AW-1:0]     digits_q,   digits_d;
    logic                overflow_q, overflow_d;

    // ------------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------------
    logic [C_AW-1:0]     w_adj;        // accumulator after add-3 stage
    logic [C_AW-1:0]     w_acc_shift;  // adjusted accumulator shifted left
    logic [WIDTH-1:0]    w_sr_shift;   // binary shift register shifted left
    logic                w_carry;      // bit leaving the top digit
    logic [WIDTH-1:0]    w_load;       // value loaded into sr on accept
    logic                w_accept;     // start taken this edge
    logic                w_finish;     // final shift this edge

    // Each digit >= 5 gets +3 before the shift so that doubling it produces
    // a correct decimal carry into the next digit. Arithmetic is strictly
    // 4 bits wide; no carry propagates between digits here.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5)
                                   ? (acc_q[4*g +: 4] + 4'd3)
                                   : acc_q[4*g +: 4];
        end
    endgenerate

    // {acc, sr} shifts left by one as a single long register
    assign w_carry     = w_adj[C_AW-1];
    assign w_acc_shift = {w_adj[C_AW-2:0], sr_q[WIDTH-1]};
    assign w_sr_shift  = {sr_q[WIDTH-2:0], 1'b0};

    assign w_accept = (state_q == S_IDLE)  && bus.start;
    assign w_finish = (state_q == S_SHIFT) && (count_q == '0);

`ifdef SIGNED_EN
    // Magnitude in WIDTH bits. The most negative value maps onto itself,
    // which read as unsigned is exactly 2^(WIDTH-1): the right magnitude.
    assign w_load = bus.binary[WIDTH-1] ? (WIDTH'(0) - bus.binary)
                                        : bus.binary;
`else
    assign w_load = bus.binary;
`endif

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;           // done is a single-cycle pulse
        digits_d   = digits_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    sr_d    = w_load;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = C_LAST;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sr_d  = w_sr_shift;
                acc_d = w_acc_shift;
                // Any bit leaving the top digit means the full value needs
                // more than DIGITS digits; the lower digits stay exact
                // modulo 10^DIGITS because carries only move upward.
                ovf_d = ovf_q | w_carry;
                if (w_finish) begin
                    digits_d   = w_acc_shift;
                    overflow_d = ovf_q | w_carry;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sign tracking
    // ------------------------------------------------------------------------
`ifdef SIGNED_EN
    logic neg_pend_q;   // sign of the conversion in flight
    logic negative_q;   // sign of the last completed conversion

    always_ff @(posedge clock) begin
        if (reset) begin
            neg_pend_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            if (w_accept) begin
                neg_pend_q <= bus.binary[WIDTH-1];
            end
            if (w_finish) begin
                negative_q <= neg_pend_q;
            end
        end
    end

    assign bus.negative = negative_q;
`else
    assign bus.negative = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.digits   = digits_q;
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_dec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_dec_seq
//  Description : Scoreboard bench for bin_to_dec_seq. Two converters share
//                the clock/reset: A (WIDTH=32, DIGITS=10) and B (WIDTH=32,
//                DIGITS=8) for the overflow cases. Stimulus pushes hand-
//                computed results into per-instance queues; monitors pop and
//                compare on every done pulse, including the done cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_dec_seq;

    localparam int W = 32;

    typedef struct {
        logic [39:0] dig;
        logic        ovf;
        logic        neg;
        longint      cyc;
    } exp_t;

    logic   clock;
    logic   reset;
    longint cyc;
    int     total;
    int     bad;
    exp_t   qa[$];
    exp_t   qb[$];

    bin_to_dec_seq_if #(.WIDTH(W), .DIGITS(10)) ifa ();
    bin_to_dec_seq_if #(.WIDTH(W), .DIGITS(8))  ifb ();

    bin_to_dec_seq #(.WIDTH(W), .DIGITS(10)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    bin_to_dec_seq #(.WIDTH(W), .DIGITS(8)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Hand-computed expectations that depend on the signed option
`ifdef SIGNED_EN
    localparam logic [39:0] E_FFFF_A = 40'h0000000001;
    localparam logic        N_FFFF   = 1'b1;
    localparam logic [39:0] E_8000_A = 40'h2147483648;
    localparam logic        N_8000   = 1'b1;
    localparam logic [39:0] E_FFFF_B = 40'h0000000001;
    localparam logic        O_FFFF_B = 1'b0;
`else
    localparam logic [39:0] E_FFFF_A = 40'h4294967295;
    localparam logic        N_FFFF   = 1'b0;
    localparam logic [39:0] E_8000_A = 40'h2147483648;
    localparam logic        N_8000   = 1'b0;
    localparam logic [39:0] E_FFFF_B = 40'h0094967295;
    localparam logic        O_FFFF_B = 1'b1;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        if (ifa.done === 1'b1) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_digits",   64'(ifa.digits),   64'(e.dig));
                chk("a_overflow", 64'(ifa.overflow), 64'(e.ovf));
                chk("a_negative", 64'(ifa.negative), 64'(e.neg));
                chk("a_latency",  64'(cyc),          64'(e.cyc));
            end
        end
    end

    always @(negedge clock) begin
        if (ifb.done === 1'b1) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_digits",   64'(ifb.digits),   64'(e.dig));
                chk("b_overflow", 64'(ifb.overflow), 64'(e.ovf));
                chk("b_negative", 64'(ifb.negative), 64'(e.neg));
                chk("b_latency",  64'(cyc),          64'(e.cyc));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at a negedge)
    // ------------------------------------------------------------------------
    task automatic go(input bit sel_b, input logic [31:0] v, input logic [39:0] d,
                      input logic o, input logic n, input bit push);
        exp_t e;
        if (sel_b) begin
            chk("b_idle_before_start", 64'(ifb.busy), 64'(0));
            ifb.start  = 1'b1;
            ifb.binary = v;
        end else begin
            chk("a_idle_before_start", 64'(ifa.busy), 64'(0));
            ifa.start  = 1'b1;
            ifa.binary = v;
        end
        @(posedge clock);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        e.dig = d;
        e.ovf = o;
        e.neg = n;
        e.cyc = cyc + W;
        if (push) begin
            if (sel_b) qb.push_back(e);
            else       qa.push_back(e);
        end
        if (sel_b) chk("b_busy_after_accept", 64'(ifb.busy), 64'(1));
        else       chk("a_busy_after_accept", 64'(ifa.busy), 64'(1));
    endtask

    task automatic wait_done(input bit sel_b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if ((sel_b ? ifb.done : ifa.done) === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got no done expected done within 100 cycles", sel_b ? "b" : "a");
        end
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        ifa.start  = 1'b0;
        ifa.binary = '0;
        ifb.start  = 1'b0;
        ifb.binary = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy",     64'(ifa.busy),     64'(0));
        chk("rst_done",     64'(ifa.done),     64'(0));
        chk("rst_digits",   64'(ifa.digits),   64'(0));
        chk("rst_overflow", 64'(ifa.overflow), 64'(0));
        chk("rst_negative", 64'(ifa.negative), 64'(0));
        chk("rst_b_digits", 64'(ifb.digits),   64'(0));
        reset = 1'b0;
        @(negedge clock);

        // Basic conversions on A
        go(1'b0, 32'd0,          40'h0, 1'b0, 1'b0,   1'b1); wait_done(1'b0); @(negedge clock);
        go(1'b0, 32'hFFFF_FFFF,  E_FFFF_A, 1'b0, N_FFFF, 1'b1); wait_done(1'b0); @(negedge clock);
        go(1'b0, 32'h8000_0000,  E_8000_A, 1'b0, N_8000, 1'b1); wait_done(1'b0); @(negedge clock);

        // Start while busy is ignored; binary change mid-conversion too
        go(1'b0, 32'd12345, 40'h12345, 1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clock);
        chk("a_busy_mid", 64'(ifa.busy), 64'(1));
        ifa.start  = 1'b1;
        ifa.binary = 32'd999;
        @(negedge clock);
        ifa.start = 1'b0;
        wait_done(1'b0);
        // Back-to-back: start on the done cycle
        go(1'b0, 32'd999, 40'h999, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0);
        repeat (3) @(negedge clock);
        chk("a_digits_hold", 64'(ifa.digits), 64'(40'h999));

        // Overflow behaviour on the 8-digit instance
        go(1'b1, 32'd100000000, 40'h00000000, 1'b1, 1'b0, 1'b1); wait_done(1'b1); @(negedge clock);
        go(1'b1, 32'd99999999,  40'h99999999, 1'b0, 1'b0, 1'b1); wait_done(1'b1); @(negedge clock);
        go(1'b1, 32'hFFFF_FFFF, E_FFFF_B, O_FFFF_B, N_FFFF, 1'b1); wait_done(1'b1); @(negedge clock);

        // Reset mid-conversion aborts without a done pulse
        go(1'b0, 32'd5678, 40'h5678, 1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy",     64'(ifa.busy),     64'(0));
        chk("abort_done",     64'(ifa.done),     64'(0));
        chk("abort_digits",   64'(ifa.digits),   64'(0));
        chk("abort_overflow", 64'(ifa.overflow), 64'(0));
        chk("abort_negative", 64'(ifa.negative), 64'(0));
        repeat (40) @(negedge clock);

        go(1'b0, 32'd5678, 40'h5678, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0);
        repeat (2) @(negedge clock);

        chk("a_queue_empty", 64'(qa.size()), 64'(0));
        chk("b_queue_empty", 64'(qb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
